// File: rtl/vram_fill_arbiter.sv
// Shares VRAM port B between two rectangle-fill requesters. Pixels are written
// only inside the vertical-blank window that follows each vga_end pulse.
module vram_fill_arbiter #(
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480,
  parameter int VBLANK_CYC = 35000
) (
  input  logic        clk_25mhz,
  input  logic        RST_N,
  input  logic        vga_end,
  input  logic        r0_req,
  input  logic [9:0]  r0_x,
  input  logic [8:0]  r0_y,
  input  logic [9:0]  r0_w,
  input  logic [8:0]  r0_h,
  input  logic [8:0]  r0_color,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic [9:0]  r1_x,
  input  logic [8:0]  r1_y,
  input  logic [9:0]  r1_w,
  input  logic [8:0]  r1_h,
  input  logic [8:0]  r1_color,
  output logic        r1_ack,
  output logic [18:0] vram_addrb,
  output logic [8:0]  vram_dinb,
  output logic        vram_web,
  output logic        busy,
  output logic        in_window
);

  localparam int CNT_W = $clog2(VBLANK_CYC + 1);
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(VBLANK_CYC);
  localparam logic [CNT_W-1:0] WIN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_ZERO = CNT_W'(0);
  localparam logic [18:0] SCR_W19 = 19'(SCR_W);
  localparam logic [18:0] SCR_H19 = 19'(SCR_H);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  // Visible extent of a span starting at pos: zero when it starts off-screen.
  function automatic logic [18:0] clip_len(input logic [18:0] pos,
                                           input logic [18:0] len,
                                           input logic [18:0] lim);
    if (pos >= lim) begin
      clip_len = 19'd0;
    end else if (len > (lim - pos)) begin
      clip_len = lim - pos;
    end else begin
      clip_len = len;
    end
  endfunction

  logic [CNT_W-1:0] win_cnt_r;
  logic [1:0]       state_r, state_n;
  logic             prio_r1_r, gnt_r1_r;
  logic [9:0]       x_r, w_r;
  logic [8:0]       y_r, h_r, color_r;
  logic [18:0]      row_base_r, col_r, row_r, last_col_r, last_row_r;

  logic        req0_s, req1_s, grant_s, pick_r1_s, last_pix_s, skip_s;
  logic [18:0] y_ext_s, row_base_s, eff_w_s, eff_h_s;

  // Blank-window down-counter; in_window mirrors "count will be nonzero".
  always_ff @(posedge clk_25mhz or negedge RST_N) begin
    if (!RST_N) begin
      win_cnt_r <= WIN_ZERO;
      in_window <= 1'b0;
    end else if (vga_end) begin
      win_cnt_r <= WIN_LOAD;
      in_window <= 1'b1;
    end else if (win_cnt_r != WIN_ZERO) begin
      win_cnt_r <= win_cnt_r - WIN_ONE;
      in_window <= (win_cnt_r != WIN_ONE);
    end else begin
      in_window <= 1'b0;
    end
  end

  // Rectangle geometry from the latched request, used in LOAD.
  always_comb begin
    y_ext_s    = {10'd0, y_r};
    row_base_s = (y_ext_s << 9) + (y_ext_s << 7) + {9'd0, x_r};
    eff_w_s    = clip_len({9'd0, x_r}, {9'd0, w_r}, SCR_W19);
    eff_h_s    = clip_len(y_ext_s, {10'd0, h_r}, SCR_H19);
    skip_s     = (eff_w_s == 19'd0) || (eff_h_s == 19'd0);
  end

  // A requester is ignored on its own ack cycle, before it can drop req.
  always_comb begin
    req0_s     = r0_req & ~r0_ack;
    req1_s     = r1_req & ~r1_ack;
    last_pix_s = (col_r == last_col_r) && (row_r == last_row_r);
    grant_s    = 1'b0;
    pick_r1_s  = 1'b0;
    state_n    = state_r;
    case (state_r)
      IDLE: begin
        if (req0_s || req1_s) begin
          grant_s   = 1'b1;
          pick_r1_s = (req0_s && req1_s) ? prio_r1_r : req1_s;
          state_n   = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (skip_s) begin
          state_n = ACK;
        end else begin
          state_n = FILL;
        end
      end
      FILL: begin
        if (in_window && last_pix_s) begin
          state_n = ACK;
        end else begin
          state_n = FILL;
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sequencer and registered port-B outputs.
  always_ff @(posedge clk_25mhz or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= IDLE;
      prio_r1_r  <= 1'b0;
      gnt_r1_r   <= 1'b0;
      x_r        <= 10'd0;
      w_r        <= 10'd0;
      y_r        <= 9'd0;
      h_r        <= 9'd0;
      color_r    <= 9'd0;
      row_base_r <= 19'd0;
      col_r      <= 19'd0;
      row_r      <= 19'd0;
      last_col_r <= 19'd0;
      last_row_r <= 19'd0;
      vram_addrb <= 19'd0;
      vram_dinb  <= 9'd0;
      vram_web   <= 1'b0;
      busy       <= 1'b0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
    end else begin
      state_r  <= state_n;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      vram_web <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            gnt_r1_r  <= pick_r1_s;
            prio_r1_r <= ~pick_r1_s;
            busy      <= 1'b1;
            x_r       <= pick_r1_s ? r1_x : r0_x;
            y_r       <= pick_r1_s ? r1_y : r0_y;
            w_r       <= pick_r1_s ? r1_w : r0_w;
            h_r       <= pick_r1_s ? r1_h : r0_h;
            color_r   <= pick_r1_s ? r1_color : r0_color;
          end
        end
        LOAD: begin
          row_base_r <= row_base_s;
          last_col_r <= eff_w_s - 19'd1;
          last_row_r <= eff_h_s - 19'd1;
          col_r      <= 19'd0;
          row_r      <= 19'd0;
        end
        FILL: begin
          if (in_window) begin
            vram_web   <= 1'b1;
            vram_addrb <= row_base_r + col_r;
            vram_dinb  <= color_r;
            if (col_r == last_col_r) begin
              col_r      <= 19'd0;
              row_r      <= row_r + 19'd1;
              row_base_r <= row_base_r + SCR_W19;
            end else begin
              col_r <= col_r + 19'd1;
            end
          end
        end
        ACK: begin
          r0_ack <= ~gnt_r1_r;
          r1_ack <= gnt_r1_r;
          busy   <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter: a long-window instance (100 clocks)
// for fills and arbitration, a short-window instance (10 clocks) for pausing.
module tb_vram_fill_arbiter;

  typedef struct {
    int x; int y; int w; int h; int color; int n; int first; int last;
  } vec_t;
  typedef struct { int addr; int data; int cyc; } wr_t;

  logic clk_25mhz, RST_N, vga_end;
  logic r0_req, r1_req;
  logic [9:0] r0_x, r0_w, r1_x, r1_w;
  logic [8:0] r0_y, r0_h, r0_color, r1_y, r1_h, r1_color;

  logic ack0_a, ack1_a, web_a, busy_a, inw_a;
  logic ack0_b, ack1_b, web_b, busy_b, inw_b;
  logic [18:0] addr_a, addr_b;
  logic [8:0]  din_a, din_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack0_n = 0, ack1_n = 0, ack0_c = 0, ack1_c = 0;
  int ackb_n = 0, ackb_c = 0;
  wr_t wq_a[$];
  wr_t wq_b[$];
  vec_t vt[7];

  vram_fill_arbiter #(.SCR_W(640), .SCR_H(480), .VBLANK_CYC(100)) u_a (
    .clk_25mhz(clk_25mhz), .RST_N(RST_N), .vga_end(vga_end),
    .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y), .r0_w(r0_w), .r0_h(r0_h),
    .r0_color(r0_color), .r0_ack(ack0_a),
    .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y), .r1_w(r1_w), .r1_h(r1_h),
    .r1_color(r1_color), .r1_ack(ack1_a),
    .vram_addrb(addr_a), .vram_dinb(din_a), .vram_web(web_a),
    .busy(busy_a), .in_window(inw_a)
  );

  vram_fill_arbiter #(.SCR_W(640), .SCR_H(480), .VBLANK_CYC(10)) u_b (
    .clk_25mhz(clk_25mhz), .RST_N(RST_N), .vga_end(vga_end),
    .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y), .r0_w(r0_w), .r0_h(r0_h),
    .r0_color(r0_color), .r0_ack(ack0_b),
    .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y), .r1_w(r1_w), .r1_h(r1_h),
    .r1_color(r1_color), .r1_ack(ack1_b),
    .vram_addrb(addr_b), .vram_dinb(din_b), .vram_web(web_b),
    .busy(busy_b), .in_window(inw_b)
  );

  initial begin
    clk_25mhz = 1'b0;
    forever #5 clk_25mhz = ~clk_25mhz;
  end

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // Write and ack log, sampled mid-cycle.
  always @(negedge clk_25mhz) begin
    if (web_a) wq_a.push_back('{int'(addr_a), int'(din_a), cyc});
    if (web_b) wq_b.push_back('{int'(addr_b), int'(din_b), cyc});
    if (ack0_a) begin ack0_n++; ack0_c = cyc; end
    if (ack1_a) begin ack1_n++; ack1_c = cyc; end
    if (ack0_b) begin ackb_n++; ackb_c = cyc; end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_25mhz);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; vga_end = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic pulse_end();
    tick();
    vga_end = 1'b1;
    tick();
    vga_end = 1'b0;
  endtask

  // Raise the enabled requests, drop each on its ack, report who finished first.
  task automatic serve(input bit en0, input bit en1, output int first, output int gap);
    int c0, c1;
    bit got0, got1;
    c0 = ack0_n; c1 = ack1_n; got0 = !en0; got1 = !en1; first = -1;
    r0_req = en0; r1_req = en1;
    for (int i = 0; i < 300; i++) begin
      if (got0 && got1) break;
      tick();
      if (!got0 && ack0_n != c0) begin got0 = 1'b1; r0_req = 1'b0; if (first < 0) first = 0; end
      if (!got1 && ack1_n != c1) begin got1 = 1'b1; r1_req = 1'b0; if (first < 0) first = 1; end
    end
    chk("serve_done", int'(got0 && got1), 1);
    r0_req = 1'b0; r1_req = 1'b0;
    gap = (ack1_c > ack0_c) ? ack1_c - ack0_c : ack0_c - ack1_c;
    tick();
  endtask

  task automatic set_r0(input int x, input int y, input int w, input int h, input int c);
    r0_x = 10'(x); r0_y = 9'(y); r0_w = 10'(w); r0_h = 9'(h); r0_color = 9'(c);
  endtask

  task automatic set_r1(input int x, input int y, input int w, input int h, input int c);
    r1_x = 10'(x); r1_y = 9'(y); r1_w = 10'(w); r1_h = 9'(h); r1_color = 9'(c);
  endtask

  initial begin
    int base, req_c, first, gap, n, ew, eh, idx, errs, a0, a1;
    vt[0] = '{2, 3, 4, 2, 'h1C0, 8, 1922, 2565};
    vt[1] = '{0, 0, 3, 1, 'h03F, 3, 0, 2};
    vt[2] = '{638, 479, 10, 4, 'h155, 2, 307198, 307199};
    vt[3] = '{0, 0, 0, 5, 'h1FF, 0, 0, 0};
    vt[4] = '{640, 0, 5, 1, 'h1FF, 0, 0, 0};
    vt[5] = '{5, 480, 1, 1, 'h1FF, 0, 0, 0};
    vt[6] = '{630, 10, 20, 3, 'h0AA, 30, 7030, 8319};

    set_r0(0, 0, 0, 0, 0);
    set_r1(0, 0, 0, 0, 0);
    do_reset();
    chk("rst_web", int'({web_a, web_b}), 0);
    chk("rst_busy", int'({busy_a, busy_b}), 0);
    chk("rst_window", int'({inw_a, inw_b}), 0);
    chk("rst_ack", int'({ack0_a, ack1_a, ack0_b, ack1_b}), 0);
    chk("rst_addr", int'(addr_a) + int'(addr_b), 0);
    chk("rst_din", int'(din_a) + int'(din_b), 0);

    // Single fills against the clipping model and hand-computed endpoints.
    for (int i = 0; i < 7; i++) begin
      pulse_end();
      set_r0(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].color);
      base = wq_a.size();
      req_c = cyc;
      serve(1'b1, 1'b0, first, gap);
      n = wq_a.size() - base;
      chk($sformatf("v%0d_count", i), n, vt[i].n);
      if (vt[i].n > 0 && n > 0) begin
        chk($sformatf("v%0d_first", i), wq_a[base].addr, vt[i].first);
        chk($sformatf("v%0d_last", i), wq_a[wq_a.size() - 1].addr, vt[i].last);
        chk($sformatf("v%0d_ack_lat", i), ack0_c - wq_a[wq_a.size() - 1].cyc, 1);
        ew = (vt[i].x >= 640) ? 0 : ((vt[i].w < 640 - vt[i].x) ? vt[i].w : 640 - vt[i].x);
        eh = (vt[i].y >= 480) ? 0 : ((vt[i].h < 480 - vt[i].y) ? vt[i].h : 480 - vt[i].y);
        idx = 0; errs = 0;
        for (int r = 0; r < eh; r++)
          for (int c = 0; c < ew; c++) begin
            if (idx < n) begin
              if (wq_a[base + idx].addr != (vt[i].y + r) * 640 + vt[i].x + c) errs++;
              if (wq_a[base + idx].data != vt[i].color) errs++;
              if (idx > 0 && wq_a[base + idx].cyc != wq_a[base + idx - 1].cyc + 1) errs++;
            end
            idx++;
          end
        chk($sformatf("v%0d_seq", i), errs, 0);
      end else begin
        chk($sformatf("v%0d_skip_lat", i), int'(ack0_c > req_c && ack0_c - req_c <= 3), 1);
      end
    end

    // Round-robin arbitration.
    do_reset();
    pulse_end();
    set_r0(0, 0, 2, 1, 'h001);
    set_r1(0, 1, 2, 1, 'h002);
    base = wq_a.size();
    serve(1'b1, 1'b1, first, gap);
    chk("arb1_first", first, 0);
    chk("arb1_gap", gap, 5);
    chk("arb1_r1_addr", (wq_a.size() == base + 4) ? wq_a[base + 2].addr : -1, 640);
    chk("arb1_r1_data", (wq_a.size() == base + 4) ? wq_a[base + 3].data : -1, 'h002);
    pulse_end();
    serve(1'b1, 1'b0, first, gap);
    pulse_end();
    serve(1'b1, 1'b1, first, gap);
    chk("arb2_first", first, 1);
    chk("arb2_gap", gap, 5);

    // Fill spanning several short windows on the 10-clock instance.
    do_reset();
    set_r0(0, 0, 25, 1, 'h007);
    base = wq_b.size();
    a0 = ackb_n;
    r0_req = 1'b1;
    repeat (6) tick();
    chk("win_closed", int'(inw_b), 0);
    chk("win_pre_writes", wq_b.size() - base, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_end();
      chk($sformatf("win%0d_open", k), int'(inw_b), 1);
      n = wq_b.size();
      for (int t = 0; t < 20; t++) begin
        tick();
        if (ackb_n != a0) r0_req = 1'b0;
      end
      chk($sformatf("win%0d_writes", k), wq_b.size() - n, (k < 2) ? 10 : 5);
      chk($sformatf("win%0d_closed", k), int'(inw_b), 0);
    end
    r0_req = 1'b0;
    chk("win_acks", ackb_n - a0, 1);
    errs = 0;
    for (int i = base; i < wq_b.size(); i++)
      if (wq_b[i].addr != i - base) errs++;
    chk("win_addr_seq", errs, 0);
    chk("win_ack_lat", (wq_b.size() > 0) ? ackb_c - wq_b[wq_b.size() - 1].cyc : -1, 1);

    // Reset in the middle of a fill, then a fresh request.
    do_reset();
    pulse_end();
    set_r0(0, 5, 20, 1, 'h0F0);
    base = wq_a.size();
    a0 = ack0_n;
    r0_req = 1'b1;
    for (int i = 0; i < 100 && (wq_a.size() - base) < 5; i++) tick();
    chk("rm_five_writes", wq_a.size() - base, 5);
    chk("rm_busy_before", int'(busy_a), 1);
    RST_N = 1'b0;
    #1;
    chk("rm_web_now", int'(web_a), 0);
    chk("rm_busy_now", int'(busy_a), 0);
    tick(); tick();
    r0_req = 1'b0;
    RST_N = 1'b1;
    repeat (30) tick();
    chk("rm_no_more_writes", wq_a.size() - base, 5);
    chk("rm_no_ack", ack0_n - a0, 0);
    pulse_end();
    set_r1(10, 0, 3, 1, 'h1FF);
    base = wq_a.size();
    a1 = ack1_n;
    serve(1'b0, 1'b1, first, gap);
    chk("rm_r1_ack", ack1_n - a1, 1);
    chk("rm_r1_count", wq_a.size() - base, 3);
    errs = 0;
    for (int i = base; i < wq_a.size(); i++) begin
      if (wq_a[i].addr != 10 + i - base) errs++;
      if (wq_a[i].data != 'h1FF) errs++;
    end
    chk("rm_r1_seq", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
